// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller for a dual-port FIFO_MEM array.
// Owns binary read/write pointers (ASIZE+1 bits, wrap modulo 2*DEPTH) and drives
// the memory write enable and both addresses. Full/empty and level are registered
// and computed from the next-state pointers, so there is no extra flag latency.
// Optional build macro: SFIFO_ERR_EN enables the sticky overflow/underflow flags;
// when it is undefined both flags are tied low and clr_err is ignored.
module sync_fifo_ctrl #(
   parameter int ASIZE    = 4,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             winc,
   input  logic             rinc,
   input  logic             clr_err,
   output logic             mem_wen,
   output logic [ASIZE-1:0] mem_waddr,
   output logic [ASIZE-1:0] mem_raddr,
   output logic             wfull,
   output logic             rempty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [ASIZE:0]   level,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [ASIZE:0] AF_L = AF_LEVEL[ASIZE:0];
   localparam logic [ASIZE:0] AE_L = AE_LEVEL[ASIZE:0];

   logic [ASIZE:0] r_wptr, r_rptr, r_level;
   logic           r_full, r_empty;
   logic           w_wacc, w_racc;
   logic [ASIZE:0] w_wptr_nxt, w_rptr_nxt;
   logic           w_full_nxt, w_empty_nxt;

   // Accept qualification; a write while full is always rejected (no bypass).
   always_comb begin
      w_wacc = winc & ~r_full;
      w_racc = rinc & ~r_empty;
   end

   // Next-state pointers and the flags they imply.
   always_comb begin
      w_wptr_nxt  = r_wptr + {{ASIZE{1'b0}}, w_wacc};
      w_rptr_nxt  = r_rptr + {{ASIZE{1'b0}}, w_racc};
      w_full_nxt  = (w_wptr_nxt[ASIZE] != w_rptr_nxt[ASIZE]) &&
                    (w_wptr_nxt[ASIZE-1:0] == w_rptr_nxt[ASIZE-1:0]);
      w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
   end

   // Pointer, level and full/empty registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_wptr  <= w_wptr_nxt;
         r_rptr  <= w_rptr_nxt;
         r_level <= w_wptr_nxt - w_rptr_nxt;
         r_full  <= w_full_nxt;
         r_empty <= w_empty_nxt;
      end
   end

   // Memory interface and status decode; the write strobe is held off during reset.
   always_comb begin
      mem_wen      = w_wacc & rst_n;
      mem_waddr    = r_wptr[ASIZE-1:0];
      mem_raddr    = r_rptr[ASIZE-1:0];
      wfull        = r_full;
      rempty       = r_empty;
      level        = r_level;
      almost_full  = (r_level >= AF_L);
      almost_empty = (r_level <= AE_L);
   end

`ifdef SFIFO_ERR_EN
   logic r_ovf, r_udf;

   // Sticky error flags; a new event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (winc & r_full)       r_ovf <= 1'b1;
         else if (clr_err)        r_ovf <= 1'b0;
         if (rinc & r_empty)      r_udf <= 1'b1;
         else if (clr_err)        r_udf <= 1'b0;
      end
   end

   // Drive the error outputs from the sticky registers.
   always_comb begin
      overflow  = r_ovf;
      underflow = r_udf;
   end
`else
   logic w_unused_clr;

   // Error reporting disabled: flags tied low, clear input has no effect.
   always_comb begin
      w_unused_clr = clr_err;
      overflow     = 1'b0;
      underflow    = 1'b0;
   end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl with a FIFO_MEM model (DSIZE=8).
module tb_sync_fifo_ctrl;

   localparam int ASIZE = 4;
   localparam int DEPTH = 16;
`ifdef SFIFO_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             winc = 1'b0, rinc = 1'b0, clr_err = 1'b0;
   logic [7:0]       wdata = 8'h00;
   logic             mem_wen, wfull, rempty, almost_full, almost_empty;
   logic             overflow, underflow;
   logic [ASIZE-1:0] mem_waddr, mem_raddr;
   logic [ASIZE:0]   level;
   logic [7:0]       mem [DEPTH];
   logic [7:0]       rdata;

   int n_vec = 0;
   int n_err = 0;

   sync_fifo_ctrl #(.ASIZE(ASIZE), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
      .clk(clk), .rst_n(rst_n), .winc(winc), .rinc(rinc), .clr_err(clr_err),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
      .wfull(wfull), .rempty(rempty), .almost_full(almost_full),
      .almost_empty(almost_empty), .level(level),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // FIFO_MEM model
   always @(posedge clk) if (mem_wen) mem[mem_waddr] <= wdata;
   assign rdata = mem[mem_raddr];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
      #3 rst_n = 1'b1;
      cyc();
   endtask

   task automatic push_n(input int n);
      for (int i = 0; i < n; i++) begin
         winc = 1'b1; wdata = 8'(i);
         cyc();
      end
      winc = 1'b0;
   endtask

   task automatic pop_n(input int n);
      for (int i = 0; i < n; i++) begin
         rinc = 1'b1;
         cyc();
      end
      rinc = 1'b0;
   endtask

   task automatic test_reset();
      cyc();
      n_vec++;
      if ({level, rempty, wfull, almost_empty, almost_full, overflow, underflow, mem_waddr, mem_raddr} !==
          {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}) begin
         n_err++;
         $display("FAIL reset_init: level=%0d empty=%b full=%b ae=%b af=%b ovf=%b udf=%b wa=%0d ra=%0d, want 0 1 0 1 0 0 0 0 0",
                  level, rempty, wfull, almost_empty, almost_full, overflow, underflow, mem_waddr, mem_raddr);
      end
      rst_n = 1'b1;
      cyc();
      push_n(5);
      n_vec++;
      if (level !== 5'd5) begin n_err++; $display("FAIL pre_reset_level: got %0d want 5", level); end
      // assert reset mid-transfer between edges with winc still high
      winc = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({level, rempty, almost_empty, mem_wen, mem_waddr, mem_raddr} !== {5'd0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0}) begin
         n_err++;
         $display("FAIL async_reset: level=%0d empty=%b ae=%b wen=%b wa=%0d ra=%0d, want 0 1 1 0 0 0",
                  level, rempty, almost_empty, mem_wen, mem_waddr, mem_raddr);
      end
      #2 rst_n = 1'b1;
      winc = 1'b0;
      cyc();
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         winc = 1'b1; wdata = 8'(i);
         #1;
         n_vec++;
         if (mem_wen !== 1'b1 || mem_waddr !== 4'(i)) begin
            n_err++; $display("FAIL fill_wen[%0d]: wen=%b wa=%0d want 1 %0d", i, mem_wen, mem_waddr, i);
         end
         cyc();
         n_vec++;
         if (level !== 5'(i + 1) || almost_full !== (i + 1 >= 12) || wfull !== (i + 1 == DEPTH) || rempty !== 1'b0) begin
            n_err++;
            $display("FAIL fill_flags[%0d]: level=%0d af=%b full=%b empty=%b want %0d %b %b 0",
                     i, level, almost_full, wfull, rempty, i + 1, (i + 1 >= 12), (i + 1 == DEPTH));
         end
      end
      winc = 1'b1; wdata = 8'hAA;
      #1;
      n_vec++;
      if (mem_wen !== 1'b0) begin n_err++; $display("FAIL overfill_wen: got %b want 0", mem_wen); end
      cyc();
      winc = 1'b0;
      n_vec++;
      if (level !== 5'd16 || overflow !== ERR || wfull !== 1'b1) begin
         n_err++; $display("FAIL overfill: level=%0d ovf=%b full=%b want 16 %b 1", level, overflow, wfull, ERR);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < DEPTH; i++) begin
         rinc = 1'b1;
         #1;
         n_vec++;
         if (rdata !== 8'(i) || mem_raddr !== 4'(i)) begin
            n_err++; $display("FAIL drain_data[%0d]: rdata=%h ra=%0d want %h %0d", i, rdata, mem_raddr, 8'(i), i);
         end
         cyc();
         n_vec++;
         if (level !== 5'(15 - i) || rempty !== (i == 15) || almost_empty !== (15 - i <= 2) || wfull !== 1'b0) begin
            n_err++;
            $display("FAIL drain_flags[%0d]: level=%0d empty=%b ae=%b full=%b want %0d %b %b 0",
                     i, level, rempty, almost_empty, wfull, 15 - i, (i == 15), (15 - i <= 2));
         end
      end
      n_vec++;
      if (mem_raddr !== 4'd0) begin n_err++; $display("FAIL raddr_wrap: got %0d want 0", mem_raddr); end
      rinc = 1'b1;
      cyc();
      rinc = 1'b0;
      n_vec++;
      if (mem_raddr !== 4'd0 || mem_waddr !== 4'd0 || level !== 5'd0 || underflow !== ERR) begin
         n_err++; $display("FAIL underread: ra=%0d wa=%0d level=%0d udf=%b want 0 0 0 %b", mem_raddr, mem_waddr, level, underflow, ERR);
      end
   endtask

   task automatic test_back_to_back();
      // empty: only the write goes in
      winc = 1'b1; rinc = 1'b1; wdata = 8'h55;
      #1;
      n_vec++;
      if (mem_wen !== 1'b1) begin n_err++; $display("FAIL simul_empty_wen: got %b want 1", mem_wen); end
      cyc();
      n_vec++;
      if (level !== 5'd1 || rempty !== 1'b0 || mem_raddr !== 4'd0) begin
         n_err++; $display("FAIL simul_empty: level=%0d empty=%b ra=%0d want 1 0 0", level, rempty, mem_raddr);
      end
      rinc = 1'b0;
      push_n(4);
      winc = 1'b1; rinc = 1'b1;
      cyc();
      n_vec++;
      if (level !== 5'd5 || mem_waddr !== 4'd6 || mem_raddr !== 4'd1) begin
         n_err++; $display("FAIL simul_mid: level=%0d wa=%0d ra=%0d want 5 6 1", level, mem_waddr, mem_raddr);
      end
      winc = 1'b0; rinc = 1'b0;
      push_n(11);
      n_vec++;
      if (wfull !== 1'b1) begin n_err++; $display("FAIL simul_prefull: full=%b want 1", wfull); end
      winc = 1'b1; rinc = 1'b1;
      #1;
      n_vec++;
      if (mem_wen !== 1'b0) begin n_err++; $display("FAIL simul_full_wen: got %b want 0", mem_wen); end
      cyc();
      winc = 1'b0; rinc = 1'b0;
      n_vec++;
      if (level !== 5'd15 || wfull !== 1'b0 || mem_waddr !== 4'd1 || mem_raddr !== 4'd2) begin
         n_err++; $display("FAIL simul_full: level=%0d full=%b wa=%0d ra=%0d want 15 0 1 2", level, wfull, mem_waddr, mem_raddr);
      end
   endtask

   task automatic test_random();
      logic [7:0] sb [$];
      int cnt = 0;
      logic [3:0] wa = 4'd0, ra = 4'd0;
      bit wexp, rexp;
      pulse_reset();
      for (int c = 0; c < 200; c++) begin
         winc  = ($urandom_range(99) < ((c < 100) ? 75 : 30));
         rinc  = ($urandom_range(99) < ((c < 100) ? 40 : 70));
         wdata = 8'($urandom);
         wexp  = winc && (cnt < DEPTH);
         rexp  = rinc && (cnt > 0);
         #1;
         n_vec++;
         if (mem_wen !== wexp || mem_waddr !== wa || mem_raddr !== ra) begin
            n_err++; $display("FAIL rand_ctl[%0d]: wen=%b wa=%0d ra=%0d want %b %0d %0d", c, mem_wen, mem_waddr, mem_raddr, wexp, wa, ra);
         end
         if (rexp) begin
            n_vec++;
            if (rdata !== sb[0]) begin n_err++; $display("FAIL rand_data[%0d]: got %h want %h", c, rdata, sb[0]); end
         end
         cyc();
         if (wexp) begin sb.push_back(wdata); wa++; cnt++; end
         if (rexp) begin void'(sb.pop_front()); ra++; cnt--; end
         n_vec++;
         if (level !== 5'(cnt) || wfull !== (cnt == DEPTH) || rempty !== (cnt == 0) ||
             almost_full !== (cnt >= 12) || almost_empty !== (cnt <= 2)) begin
            n_err++;
            $display("FAIL rand_flags[%0d]: level=%0d full=%b empty=%b af=%b ae=%b want level %0d", c, level, wfull, rempty, almost_full, almost_empty, cnt);
         end
      end
      winc = 1'b0; rinc = 1'b0;
   endtask

   task automatic test_err_clear();
      pulse_reset();
      push_n(DEPTH);
      winc = 1'b1; clr_err = 1'b1;
      cyc();
      winc = 1'b0; clr_err = 1'b0;
      n_vec++;
      if (overflow !== ERR) begin n_err++; $display("FAIL set_beats_clear: ovf=%b want %b", overflow, ERR); end
      pop_n(DEPTH + 1);
      n_vec++;
      if (overflow !== ERR || underflow !== ERR) begin
         n_err++; $display("FAIL both_sticky: ovf=%b udf=%b want %b %b", overflow, underflow, ERR, ERR);
      end
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      n_vec++;
      if (overflow !== 1'b0 || underflow !== 1'b0) begin
         n_err++; $display("FAIL clr_err: ovf=%b udf=%b want 0 0", overflow, underflow);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_random();
      test_err_clear();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, want completion");
      $fatal(1, "timeout");
   end

endmodule
